// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
// Shared definitions for the bit-serial adder controller: FSM state
// encoding and the default operand width.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } sa_state_e;

  localparam int SA_DEFAULT_WIDTH = 8;

  // Bit-counter width: enough to count 0..width-1, never narrower than 1 bit.
  function automatic int sa_cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/Full_Adder_Structural_Verilog.sv
// Full_Adder_Structural_Verilog
// Gate-level 1-bit full adder cell.
// Ports:
//   X1, X2  operand bits
//   Cin     carry in
//   S       sum bit
//   Cout    carry out
module Full_Adder_Structural_Verilog (
  input  wire X1,
  input  wire X2,
  input  wire Cin,
  output wire S,
  output wire Cout
);

  wire w_x12;
  wire w_g;
  wire w_p;

  xor u_x1 (w_x12, X1, X2);
  xor u_x2 (S, w_x12, Cin);
  and u_a1 (w_g, X1, X2);
  and u_a2 (w_p, w_x12, Cin);
  or  u_o1 (Cout, w_g, w_p);

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
// Bit-serial adder controller. Latches operands on a start request, feeds
// one bit pair per clock (LSB first) through a single full adder cell,
// keeps the carry in a flop, and presents a held result with a one-cycle
// done pulse. {o_cout, o_sum} = i_a + i_b + i_cin.
// Ports:
//   i_clk    rising-edge clock
//   i_rst    asynchronous reset, active-high
//   i_start  request, sampled only in IDLE
//   i_a/i_b  operands, captured on the accepting edge
//   i_cin    carry-in, captured on the accepting edge
//   o_busy   high while in RUN
//   o_done   one-cycle pulse in DONE
//   o_sum    registered result, held between completions
//   o_cout   registered carry-out, held between completions
//
// state | meaning
// IDLE  | waiting for i_start; result outputs hold the last completion
// RUN   | one operand bit pair per edge through the full adder cell
// DONE  | single-cycle done pulse, then back to IDLE
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  localparam int CW = sa_cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  sa_state_e        r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_work;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_s;
  logic             w_cout;
  logic [WIDTH-1:0] w_work_next;

  Full_Adder_Structural_Verilog u_fa (
    .X1  (r_a[0]),
    .X2  (r_b[0]),
    .Cin (r_carry),
    .S   (w_s),
    .Cout(w_cout)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  // Written as a shift of the concatenation so WIDTH=1 needs no special case.
  assign w_work_next = WIDTH'({w_s, r_work} >> 1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_work  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_carry <= i_cin;
            r_work  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_cout;
          r_work  <= w_work_next;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == LAST_BIT) begin
            // Result registers move only here, so partial sums never show.
            r_sum   <= w_work_next;
            r_cout  <= w_cout;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_sum  = r_sum;
  assign o_cout = r_cout;

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller: computes an N-bit sum with a single 1-bit full adder cell, one operand bit per clock, LSB first. Latches operands on a start request, sequences the cell through WIDTH cycles, carries between bits in a flip-flop, and presents a held result with a one-cycle done pulse. Sits between any requester needing occasional wide additions and the existing structural full adder, trading latency for area.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1..32
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  request; sampled only in IDLE
- a  in  WIDTH  operand A, captured on the accepting edge
- b  in  WIDTH  operand B, captured on the accepting edge
- cin  in  1  carry-in, captured on the accepting edge
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse, high while in DONE
- sum  out  WIDTH  registered result, held between completions
- cout  out  1  registered carry-out, held between completions

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 on an edge → capture a, b into shift registers, carry flop ← cin, bit counter ← 0, go to RUN. start=0 → stay.
- RUN: each edge feeds the LSBs of the A/B shift registers plus the carry flop to the full adder cell. S shifts into the MSB of the working sum register; carry flop ← Cout; A/B shift right; counter++. On the edge where counter = WIDTH-1: sum ← final working sum, including that edge's S bit; cout ← that edge's Cout; go to DONE.
- DONE: one cycle, then to IDLE unconditionally.
- start in RUN or DONE is ignored; no queuing.
- a, b, cin changes after capture have no effect on the in-flight result.
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^(WIDTH+1); no truncation or saturation.
- sum/cout change only on the completing edge. They never show partial results.
- Counter width: $clog2(WIDTH), minimum 1 bit.

## Timing
- Reset (async assert, any state): state=IDLE, busy=0, done=0, sum=0, cout=0, carry/counter/shift regs=0. An in-flight operation is discarded with no done pulse.
- Reset release: the first rising edge with rst=0 may accept start.
- Accepting edge = E0. busy is high from after E0 until after edge E0+WIDTH.
- done is high for exactly one cycle, between edges E0+WIDTH and E0+WIDTH+1. sum/cout are valid from that cycle onward.
- Latency from start to done: WIDTH cycles. Throughput: one operation per WIDTH+2 cycles.
- If start is held high continuously, a new operation is accepted on edge E0+WIDTH+2, the first IDLE edge. Each operation produces exactly one done pulse.
- WIDTH=1: RUN lasts one edge. Counter comparison must still terminate correctly.

## Structure
- Shared package serial_adder_pkg holds:
  - the state encoding: IDLE=2'b00, RUN=2'b01, DONE=2'b10
  - default width constant SA_DEFAULT_WIDTH=8
- One sub-module instance: the existing Full_Adder_Structural_Verilog cell, ports X1, X2, Cin, S, Cout.
  - X1 ← A shift-reg LSB
  - X2 ← B shift-reg LSB
  - Cin ← carry flop
- The controller contains no adder logic of its own.

## Test plan
- WIDTH=8, a=0x00, b=0x00, cin=0 → done exactly 8 cycles after the accepting edge; sum=0x00, cout=0; busy high for 8 cycles.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0x7F, b=0x01, cin=0 → sum=0x80, cout=0. Previous result stays held until the second done.
- a=0xA5, b=0x5A, cin=1 → sum=0x00, cout=1. Change a/b to 0x00 on the cycle after accept; result must be unchanged.
- start held high for 40 cycles with a=0x12, b=0x34, cin=0 → done pulses 10 cycles apart, each with sum=0x46, cout=0; no extra pulses.
- Assert rst after 3 RUN edges of a=0xFF, b=0xFF → busy, done, sum, cout all 0 immediately; no done pulse. A subsequent a=0x03, b=0x04, cin=1 gives sum=0x08, cout=0.
- WIDTH=1 build: all 8 combinations of a, b, cin → {cout, sum} matches the full-adder truth table; done 1 cycle after accept.
